// File: rtl/seq_divider_32bit.sv
// Multi-cycle signed restoring divider sharing the adder's negate-flag operand convention.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module seq_divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             neg1,
  input  logic             neg2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_val, b_val, abs_a_in, abs_b_in;
  logic             b_is_zero, early_out;

  logic [WIDTH-1:0] dividend, divisor, rem, q;
  logic [CW-1:0]    count;
  logic             sign_q, sign_r, dz_pend;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    a_val     = neg1 ? -operand1 : operand1;
    b_val     = neg2 ? -operand2 : operand2;
    abs_a_in  = a_val[WIDTH-1] ? -a_val : a_val;
    abs_b_in  = b_val[WIDTH-1] ? -b_val : b_val;
    b_is_zero = (b_val == '0);
  end

`ifdef DIV_EARLY_OUT_EN
  assign early_out = !b_is_zero && (abs_a_in < abs_b_in);
`else
  assign early_out = 1'b0;
`endif

  // Restoring step: a negative difference (bit WIDTH set) means keep the shifted value.
  assign shifted = {rem, dividend[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (b_is_zero || early_out) ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend  <= '0;
      divisor   <= '0;
      rem       <= '0;
      q         <= '0;
      count     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      dz_pend   <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dividend <= abs_a_in;
            divisor  <= abs_b_in;
            q        <= '0;
            count    <= '0;
            sign_q   <= a_val[WIDTH-1] ^ b_val[WIDTH-1];
            sign_r   <= a_val[WIDTH-1];
            dz_pend  <= b_is_zero;
            // Short paths skip CALC, so the remainder is simply |a|.
            rem      <= (b_is_zero || early_out) ? abs_a_in : '0;
          end
        end
        CALC: begin
          dividend <= dividend << 1;
          q        <= {q[WIDTH-2:0], ~diff[WIDTH]};
          rem      <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
          count    <= count + CW'(1);
        end
        FIX: begin
          quotient  <= dz_pend ? '1 : (sign_q ? -q : q);
          remainder <= sign_r ? -rem : rem;
          div_zero  <= dz_pend;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
